// File: rtl/glyph_line_streamer.sv
// Glyph row streamer: fetches a font ROM row per request, applies blank/underline/
// inverse/double-width, and shifts it out MSB-first with a one-row prefetch buffer.
module glyph_line_streamer #(
  parameter int GLYPH_W = 8,
  parameter int CHAR_W  = 8,
  parameter int LINE_W  = 4,
  parameter int H0      = 8,
  parameter int H1      = 14,
  parameter int H2      = 16,
  parameter int H3      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_font,
  input  logic [CHAR_W-1:0]          req_char,
  input  logic [LINE_W-1:0]          req_line,
  input  logic [2:0]                 req_attr,
  output logic [2+CHAR_W+LINE_W-1:0] rom_addr,
  input  logic [GLYPH_W-1:0]         rom_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix,
  output logic                       pix_last,
  output logic                       busy
);
  localparam int CW = $clog2(2*GLYPH_W);
  localparam logic [CW-1:0] LAST_S = CW'(GLYPH_W-1);
  localparam logic [CW-1:0] LAST_D = CW'(2*GLYPH_W-1);

  typedef struct packed {
    logic [1:0]        font;
    logic [LINE_W-1:0] line;
    logic [2:0]        attr;   // {dbl, ul, inv}
  } req_t;

  req_t               req_q;
  logic               inflight;
  logic               buf_valid;
  logic [GLYPH_W-1:0] buf_row;
  logic               buf_dbl;
  logic               sh_valid;
  logic [GLYPH_W-1:0] sh_row;
  logic               sh_dbl;
  logic [CW-1:0]      cnt;

  logic               accept, last_hs, adv, sh_free;
  logic [31:0]        height;
  logic [GLYPH_W-1:0] row_c;

  assign rom_addr  = {req_font, req_char, req_line};
  assign req_ready = !inflight && !buf_valid;
  assign accept    = req_valid && req_ready;
  assign busy      = inflight || buf_valid || sh_valid;
  assign pix_valid = sh_valid;
  assign pix       = sh_valid && sh_row[GLYPH_W-1];
  assign pix_last  = sh_valid && (cnt == (sh_dbl ? LAST_D : LAST_S));
  assign adv       = sh_valid && pix_ready;
  assign last_hs   = adv && pix_last;
  assign sh_free   = !sh_valid || last_hs;

  always_comb begin
    case (req_q.font)
      2'd0:    height = 32'(H0);
      2'd1:    height = 32'(H1);
      2'd2:    height = 32'(H2);
      default: height = 32'(H3);
    endcase
  end

  // Lines past the font height are blank; underline replaces the bottom line.
  always_comb begin
    row_c = rom_data;
    if (32'(req_q.line) >= height)
      row_c = '0;
    else if (req_q.attr[1] && (32'(req_q.line) == height - 32'd1))
      row_c = '1;
    if (req_q.attr[0])
      row_c = ~row_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      req_q     <= '0;
      buf_valid <= 1'b0;
      buf_row   <= '0;
      buf_dbl   <= 1'b0;
      sh_valid  <= 1'b0;
      sh_row    <= '0;
      sh_dbl    <= 1'b0;
      cnt       <= '0;
    end else begin
      inflight <= accept;
      if (accept)
        req_q <= '{font: req_font, line: req_line, attr: req_attr};

      // inflight and buf_valid are never both set, so the row lands in exactly one place.
      if (inflight && !sh_free) begin
        buf_valid <= 1'b1;
        buf_row   <= row_c;
        buf_dbl   <= req_q.attr[2];
      end else if (buf_valid && last_hs) begin
        buf_valid <= 1'b0;
      end

      if (inflight && sh_free) begin
        sh_valid <= 1'b1;
        sh_row   <= row_c;
        sh_dbl   <= req_q.attr[2];
        cnt      <= '0;
      end else if (buf_valid && last_hs) begin
        sh_valid <= 1'b1;
        sh_row   <= buf_row;
        sh_dbl   <= buf_dbl;
        cnt      <= '0;
      end else if (last_hs) begin
        sh_valid <= 1'b0;
      end else if (adv) begin
        cnt <= cnt + 1'b1;
        // double width holds each bit for two pixels
        if (!sh_dbl || cnt[0])
          sh_row <= sh_row << 1;
      end
    end
  end
endmodule

// File: tb/tb_glyph_line_streamer.sv
// Bench for glyph_line_streamer: per-request pixel-list model with availability
// times, checked every cycle, plus literal row expectations for directed cases.
module tb_glyph_line_streamer;
  localparam int AW = 14;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_font = '0;
  logic [7:0] req_char = '0;
  logic [3:0] req_line = '0;
  logic [2:0] req_attr = '0;
  logic [AW-1:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic pix_valid, pix_ready = 1'b1, pix, pix_last, busy;

  glyph_line_streamer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_font(req_font), .req_char(req_char), .req_line(req_line), .req_attr(req_attr),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix(pix), .pix_last(pix_last), .busy(busy));

  always #5 clk = ~clk;

  logic [7:0] rom [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct { bit p; bit last; int avail; } px_t;
  px_t exp_q[$];
  bit  log_p[$], log_l[$];
  int  log_e[$];
  int  rows = 0, edge_n = 0, errors = 0, checks = 0, mode = 0;
  bit  acc_last = 0;

  function automatic logic [AW-1:0] mk_addr(logic [1:0] f, logic [7:0] c, logic [3:0] l);
    return {f, c, l};
  endfunction

  function automatic void push_row(logic [1:0] f, logic [3:0] l, logic [2:0] a, logic [7:0] rv, int av);
    int hs [4] = '{8, 14, 16, 16};
    int h = hs[f];
    logic [7:0] r;
    int n = a[2] ? 16 : 8;
    if (int'(l) >= h) r = 8'h00;
    else if (a[1] && int'(l) == h - 1) r = 8'hFF;
    else r = rv;
    if (a[0]) r = ~r;
    for (int k = 0; k < n; k++) begin
      px_t e;
      e.p = r[7 - (a[2] ? k / 2 : k)];
      e.last = (k == n - 1);
      e.avail = av;
      exp_q.push_back(e);
    end
    rows++;
  endfunction

  function automatic void chk(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", nm, a, e, edge_n);
    end
  endfunction

  function automatic void chk_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, a, e, edge_n);
    end
  endfunction

  // Model: each accepted row's pixels become available the cycle after the next edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      rows = 0;
      acc_last = 0;
    end else begin
      edge_n++;
      if (pix_valid && pix_ready) begin
        log_p.push_back(pix); log_l.push_back(pix_last); log_e.push_back(edge_n);
        if (exp_q.size() > 0) begin
          if (exp_q[0].last) rows--;
          void'(exp_q.pop_front());
        end
      end
      acc_last = req_valid && req_ready;
      if (acc_last) push_row(req_font, req_line, req_attr, rom[rom_addr], edge_n + 1);
    end
  end

  initial forever begin
    bit ev;
    @(negedge clk);
    ev = exp_q.size() > 0 && exp_q[0].avail <= edge_n;
    chk("pix_valid", pix_valid, ev);
    if (ev) begin
      chk("pix", pix, exp_q[0].p);
      chk("pix_last", pix_last, exp_q[0].last);
    end
    chk("req_ready", req_ready, !acc_last && (rows - int'(acc_last)) < 2);
    chk("busy", busy, acc_last || rows > 0);
  end

  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      case (mode)
        1: pix_ready = ($urandom_range(3) != 0);
        2: pix_ready = (k % 4 == 0) || (k % 4 == 3);
        default: pix_ready = 1'b1;
      endcase
      k++;
    end
  end

  task automatic issue(input logic [1:0] f, input logic [7:0] c, input logic [3:0] l, input logic [2:0] a);
    int t = 0;
    req_font = f; req_char = c; req_line = l; req_attr = a; req_valid = 1'b1;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_char = 8'($urandom);
    req_line = 4'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() > 0) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic clear_log();
    log_p.delete(); log_l.delete(); log_e.delete();
  endtask

  task automatic check_log(string nm, int n, logic [31:0] bits, logic [31:0] lasts);
    logic [31:0] gp = '0, gl = '0;
    chk_int({nm, "_count"}, log_p.size(), n);
    for (int i = 0; i < n && i < log_p.size(); i++) begin
      gp[n-1-i] = log_p[i];
      gl[n-1-i] = log_l[i];
    end
    chk_int({nm, "_pixels"}, int'(gp), int'(bits));
    chk_int({nm, "_last"}, int'(gl), int'(lasts));
  endtask

  task automatic check_reset_vals(string nm);
    chk({nm, "_req_ready"}, req_ready, 1'b1);
    chk({nm, "_pix_valid"}, pix_valid, 1'b0);
    chk({nm, "_pix"}, pix, 1'b0);
    chk({nm, "_pix_last"}, pix_last, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Plain row and first-pixel latency
    rom[mk_addr(0, 8'h41, 2)] = 8'hA5;
    clear_log();
    issue(0, 8'h41, 4'd2, 3'b000);
    chk("latency_e1", pix_valid, 1'b0);
    @(negedge clk);
    chk("latency_e2", pix_valid, 1'b1);
    wait_idle();
    check_log("plain", 8, 32'hA5, 32'h1);

    // Inverse + double width
    rom[mk_addr(0, 8'h41, 2)] = 8'h80;
    clear_log();
    issue(0, 8'h41, 4'd2, 3'b101);
    wait_idle();
    check_log("inv_dbl", 16, 32'h3FFF, 32'h1);

    // Font 1: underline line, blank line, inverted blank line
    clear_log(); issue(1, 8'h20, 4'd13, 3'b010); wait_idle();
    check_log("ul", 8, 32'hFF, 32'h1);
    clear_log(); issue(1, 8'h20, 4'd14, 3'b000); wait_idle();
    check_log("blank", 8, 32'h00, 32'h1);
    clear_log(); issue(1, 8'h20, 4'd15, 3'b001); wait_idle();
    check_log("blank_inv", 8, 32'hFF, 32'h1);

    // Back-to-back rows stream gapless
    rom[mk_addr(0, 1, 0)] = 8'hFF;
    rom[mk_addr(0, 2, 0)] = 8'h00;
    rom[mk_addr(0, 3, 0)] = 8'hF0;
    clear_log();
    issue(0, 8'd1, 4'd0, 3'b000);
    issue(0, 8'd2, 4'd0, 3'b000);
    issue(0, 8'd3, 4'd0, 3'b000);
    wait_idle();
    check_log("b2b", 24, 32'hFF00F0, 32'h010101);
    if (log_e.size() == 24) chk_int("b2b_span", log_e[23] - log_e[0], 23);

    // Backpressure pattern 1,0,0,1
    rom[mk_addr(2, 8'h55, 3)] = 8'h96;
    mode = 2;
    clear_log();
    issue(2, 8'h55, 4'd3, 3'b000);
    wait_idle();
    check_log("stall", 8, 32'h96, 32'h1);
    mode = 0;

    // Reset mid-row with a second fetch in flight
    rom[mk_addr(0, 10, 1)] = 8'h5A;
    clear_log();
    issue(0, 8'd10, 4'd1, 3'b000);
    repeat (3) @(negedge clk);
    issue(0, 8'd11, 4'd1, 3'b000);
    chk_int("pre_reset_pixels", log_p.size(), 3);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rom[mk_addr(3, 8'h7E, 5)] = 8'h3C;
    clear_log();
    issue(3, 8'h7E, 4'd5, 3'b000);
    wait_idle();
    check_log("after_reset", 8, 32'h3C, 32'h1);

    // Randomized traffic with random backpressure
    mode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(4) == 0 ? $urandom_range(12) : 0) @(negedge clk);
      issue(2'($urandom), 8'($urandom), 4'($urandom), 3'($urandom));
    end
    wait_idle();
    mode = 0;
    chk_int("final_queue", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/glyph_line_streamer.md
# glyph_line_streamer

Parametrised, pipelined successor to the font ROM path. It accepts character-line requests (font, char code, glyph line, attributes) over a valid/ready handshake and reads the glyph row from an external registered font ROM. It applies blanking, underline, inverse and double-width, then streams the row MSB-first as single pixels with backpressure. It sits between the character-map scanner and the pixel mux, and a one-row prefetch buffer keeps consecutive glyphs gapless.

## Interface
Parameters:
- GLYPH_W, 8: pixels per glyph row (rom_data width)
- CHAR_W, 8: character code width
- LINE_W, 4: glyph line index width
- H0, 8: line count of font 0
- H1, 14: line count of font 1
- H2, 16: line count of font 2
- H3, 16: line count of font 3

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request slot free
- req_font  in  2  font select
- req_char  in  CHAR_W  character code
- req_line  in  LINE_W  glyph line
- req_attr  in  3  {dbl, ul, inv}
- rom_addr  out  2+CHAR_W+LINE_W  combinational {req_font, req_char, req_line}
- rom_data  in  GLYPH_W  ROM row, valid one cycle after the address is sampled
- pix_valid  out  1  pixel present
- pix_ready  in  1  sink accepts pixel
- pix  out  1  pixel value
- pix_last  out  1  last pixel of the current row
- busy  out  1  fetch in flight, buffer full, or shifter active

## Operation
- Acceptance: a request is accepted on any edge where req_valid and req_ready are both 1.
  - The ROM samples rom_addr at that same edge.
  - An in-flight flag F is set, and req_line/req_font/req_attr are latched.
- req_ready = !F && !buf_valid. The block therefore accepts at most one request per 2 cycles, and at most one row is ever buffered.
- Row processing, at the edge after acceptance (F=1). Let H = height of the latched font.
  - If line >= H: row = 0 and rom_data is ignored.
  - Else if ul=1 and line == H-1: row = all ones.
  - Else: row = rom_data.
  - Then, if inv=1: row = ~row.
- Row placement, at that same edge; F clears.
  - The row loads into the shifter if the shifter is empty, or if its last pixel is handshaked at that edge.
  - Otherwise the row goes into the buffer (buf_valid=1).
- Shifter output:
  - Outputs row bits MSB first.
  - dbl=0: GLYPH_W pixels. dbl=1: each bit is repeated on 2 consecutive pixels, giving 2*GLYPH_W pixels.
  - The pixel counter is sized for 2*GLYPH_W.
- pix_last=1 only on the final pixel of a row.
- On a last-pixel handshake:
  - If buf_valid=1, the buffer loads into the shifter at that edge (gapless) and buf_valid clears.
  - Otherwise pix_valid drops, unless an F row loads at that same edge.
- Backpressure: while pix_valid=1 and pix_ready=0, pix, pix_last and pix_valid hold stable. A pixel is consumed only on a valid&&ready edge.
- Reset (asynchronous, any time, including mid-row or mid-fetch):
  - Clears F, buf_valid, the shifter and the counters.
  - Any in-flight ROM data is discarded.
  - Output values: req_ready=1, pix_valid=0, pix=0, pix_last=0, busy=0.

## Timing
- Acceptance at edge E0 → rom_data is valid during the following cycle → captured/processed at E1.
- Latency: if the shifter is idle, the first pixel_valid is high in the cycle after E1, i.e. 2 edges after acceptance.
- Throughput: with pix_ready tied 1, back-to-back rows stream with no idle cycle, provided each request is accepted at least 2 edges before the current row ends (holds whenever GLYPH_W ≥ 2).
- A new request can be accepted at the edge where the buffer empties into the shifter only if F=0. The ready decision uses register state before the edge; there is no combinational path from pix_ready to req_ready.
- rom_addr is the only combinational output (req inputs → rom_addr).

## Test plan
- Reset, then font 0, char 0x41, line 2, attr 0, rom_data 0xA5 → pixels 1,0,1,0,0,1,0,1 from 2 edges after accept; pix_last on the 8th; pix_valid then 0.
- Same request with attr inv=1 and dbl=1, rom_data 0x80 → 16 pixels: 0,0, then 1 ×14; pix_last on the 16th.
- Font 1 (H1=14):
  - line 13 with ul=1 → 8 ones, rom_data ignored.
  - line 14 with ul=0 → 8 zeros.
  - line 15 with inv=1 → 8 ones.
- Three requests issued ASAP with pix_ready=1, rows 0xFF, 0x00, 0xF0 → 24 contiguous valid pixels, no gap. req_ready is low while the buffer is full and returns 1 when it drains.
- Backpressure: pix_ready toggles 1,0,0,1 repeatedly during a row 0x96 → pixel sequence unchanged, outputs stable while stalled, no pixel dropped or repeated.
- Assert rst mid-row (pixel 4) with a second fetch in flight → outputs go to reset values asynchronously. After release, a new request 0x3C streams correctly with no stale pixels.
